// File: rtl/demux4_buf_pkg.sv
// Shared constants and helpers for the buffered 1-to-4 demultiplexer.
// Holds channel count, select width and a pointer-width helper.
package demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    // Number of bits needed to index v entries (v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/demux4_buf_if.sv
// Handshake bundle: one tagged input stream, four output streams, busy.
// slave = demux side, master = producer/consumer side.
interface demux4_buf_if #(
    parameter int N = 32
);
    import demux4_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel;
    logic [N-1:0]      in_data;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;
    logic [N-1:0]      out_data0;
    logic [N-1:0]      out_data1;
    logic [N-1:0]      out_data2;
    logic [N-1:0]      out_data3;
    logic              busy;

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, busy,
        output out_data0, out_data1, out_data2, out_data3
    );

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, busy,
        input  out_data0, out_data1, out_data2, out_data3
    );

endinterface

// File: rtl/demux4_buf_chan_fifo.sv
// Single-channel synchronous FIFO with registered count.
// Ports: push/din/full (write), pop/dout/empty (read, dout is head word).
module chan_fifo
    import demux4_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [N-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [N-1:0] dout,
    output logic         empty
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO refuses a push even when it pops in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is deliberately not reset; the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux4_buf.sv
// Buffered 1-to-4 demux: steers tagged input words into four channel FIFOs.
// Ports: clk, rst_n (async active-low), bus (demux4_buf_if.slave).
module demux4_buf
    import demux4_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    demux4_buf_if.slave     bus
);

    logic [NUM_CH-1:0] sel_oh;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [N-1:0]      dout [NUM_CH];

    always_comb begin
        sel_oh = '0;
        sel_oh[bus.in_sel] = 1'b1;
    end

    // in_ready depends only on FIFO state and in_sel, never on out_ready.
    assign bus.in_ready  = !full[bus.in_sel];
    assign push          = sel_oh & {NUM_CH{bus.in_valid && bus.in_ready}};
    assign bus.out_valid = ~empty;
    assign bus.busy      = |(~empty);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        chan_fifo #(
            .N     (N),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .din   (bus.in_data),
            .full  (full[k]),
            .pop   (bus.out_ready[k]),
            .dout  (dout[k]),
            .empty (empty[k])
        );
    end

    assign bus.out_data0 = dout[0];
    assign bus.out_data1 = dout[1];
    assign bus.out_data2 = dout[2];
    assign bus.out_data3 = dout[3];

endmodule

// File: doc/demux4_buf.md
# demux4_buf

Buffered 1-to-4 demultiplexer: the inverse of the 4-to-1 data-select mux. It accepts a single valid/ready input stream tagged with a 2-bit channel select and steers each word into one of four independent per-channel FIFOs, each drained by its own valid/ready consumer. It sits where one producer, such as a writeback or result bus, fans out to four consumers that may stall independently.

## Interface
- N, 32, data width in bits
- DEPTH, 2, entries per channel FIFO; power of two, minimum 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when in_valid is also high
- in_sel  input  2  destination channel 0..3
- in_data  input  N  input word
- out_valid  output  4  bit k: channel k FIFO non-empty
- out_ready  input  4  bit k: consumer k takes its head word
- out_data0..out_data3  output  N each  head word of channel 0..3; don't-care when its out_valid bit is low
- busy  output  1  any channel non-empty

## Operation
- Push: when in_valid && in_ready, write in_data into FIFO[in_sel].
- in_ready = !full[in_sel]. This depends only on FIFO state and in_sel. There is no combinational path from out_ready to in_ready.
- Pop: for each k, when out_valid[k] && out_ready[k], advance FIFO k's read pointer.
- A push and a pop on the same channel in the same cycle are both performed if the FIFO is not full. Occupancy is unchanged, and the pushed word lands behind the existing entries.
- On a full channel, the push is refused even if that channel pops in the same cycle. The next cycle accepts it.
- Words to different channels never block one another except through the shared input port. Head-of-line blocking on the input is intended.
- Ordering is FIFO within each channel. No ordering is defined across channels.
- in_data and in_sel are sampled only on an accepted push. The producer holds in_data and in_sel stable while in_valid is high and in_ready is low.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide. full is count==DEPTH; empty is count==0.
- out_valid[k] = !empty[k]. busy = |out_valid.

## Timing
- Reset: rst_n low asynchronously clears all pointers and counts. While reset is held, out_valid=0, busy=0 and in_ready=1. Data storage is not cleared.
- Reset asserted mid-transfer discards all buffered words. No partial state survives.
- Latency: a word pushed at edge t is visible on out_valid/out_data at t+1 (one cycle). It can be popped at edge t+1 at the earliest.
- Throughput: one push per cycle and one pop per channel per cycle.
- out_data is driven combinationally from FIFO storage at the read pointer. out_valid and busy are derived from registered counts.

## Structure
- Package demux4_pkg holds NUM_CH=4, SEL_W=2, and a function clog2 for pointer widths.
- Sub-module chan_fifo (parameters N, DEPTH; ports clk, rst_n, push, din, full, pop, dout, empty) is instantiated four times.
- The top level does only the in_sel decode, the push-enable steering, the in_ready mux and the output wiring.

## Test plan
- Reset and idle: hold rst_n=0 with random inputs, then release. Required: out_valid=4'b0000, busy=0 and in_ready=1 throughout reset and after release.
- Steering: push 0xA0, 0xB1, 0xC2, 0xD3 with in_sel=0,1,2,3 on consecutive cycles while out_ready=0. Required: one cycle after the last push, out_valid=4'b1111 and out_data0..3 = 0xA0, 0xB1, 0xC2, 0xD3.
- Full and backpressure (DEPTH=2): push 0x11, 0x22, 0x33 to channel 2 with out_ready=0. Required: the first two are accepted, in_ready=0 on the third, and the third is accepted on the cycle after out_ready[2] pulses. Channel 2 then pops in the order 0x11, 0x22, 0x33.
- Simultaneous push and pop: channel 1 holds one word, 0x55. Push 0x66 to channel 1 in the same cycle as the pop. Required: 0x55 is delivered, 0x66 becomes the head next cycle, and the count stays 1.
- Pointer wrap and ordering: stream 0..15 to channel 3 with random out_ready. Required: channel 3 outputs exactly 0..15 in order, and channels 0-2 never assert out_valid.
- Reset mid-operation: with all channels partly full, pulse rst_n low between clock edges. Required: out_valid=0 and busy=0 immediately, without waiting for a clock edge, and no stale word appears after reset.
